// File: rtl/tutorial_divider.sv
`default_nettype none
// tutorial_divider: sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro TUTORIAL_DIV_SIGNED_EN selects two's-complement operands (quotient truncates toward zero).
module tutorial_divider #(
    parameter int N = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Start,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero,
    output logic         Overflow
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [N-1:0]   r_dvd;
    logic [N-1:0]   r_div;
    logic [N-1:0]   r_rem;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_r;
    logic           r_done;
    logic           r_divzero;

    // The kept remainder is always below the divisor, so only the shifted/trial value needs N+1 bits.
    logic [N:0]     w_shift;
    logic [N:0]     w_trial;
    logic           w_qbit;
    logic [N:0]     w_rem_nxt;
    logic [N-1:0]   w_dvd_nxt;
    logic           w_last;
    logic           w_b_zero;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic [N-1:0]   w_q_fin;
    logic [N-1:0]   w_r_fin;

    assign w_shift   = {r_rem, r_dvd[N-1]};
    assign w_trial   = w_shift - {1'b0, r_div};
    assign w_qbit    = ~w_trial[N];
    assign w_rem_nxt = w_qbit ? w_trial : w_shift;
    assign w_dvd_nxt = {r_dvd[N-2:0], w_qbit};
    assign w_last    = (r_cnt == CW'(1));
    assign w_b_zero  = (B == '0);

`ifdef TUTORIAL_DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic r_ovf_pend;
    logic r_overflow;
    logic w_ovf_in;

    assign w_a_mag  = A[N-1] ? (~A + 1'b1) : A;
    assign w_b_mag  = B[N-1] ? (~B + 1'b1) : B;
    // Most-negative / -1 is the only quotient that does not fit; its magnitude result wraps to itself.
    assign w_ovf_in = (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
    assign w_q_fin  = r_neg_q ? (~w_dvd_nxt + 1'b1) : w_dvd_nxt;
    assign w_r_fin  = r_neg_r ? (~w_rem_nxt[N-1:0] + 1'b1) : w_rem_nxt[N-1:0];
    assign Overflow = r_overflow;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_overflow <= 1'b0;
        end else if (r_state == S_IDLE && Start) begin
            r_neg_q    <= A[N-1] ^ B[N-1];
            r_neg_r    <= A[N-1];
            r_ovf_pend <= w_ovf_in;
            if (w_b_zero) begin
                r_overflow <= 1'b0;
            end
        end else if (r_state == S_RUN && w_last) begin
            r_overflow <= r_ovf_pend;
        end
    end
`else
    assign w_a_mag  = A;
    assign w_b_mag  = B;
    assign w_q_fin  = w_dvd_nxt;
    assign w_r_fin  = w_rem_nxt[N-1:0];
    assign Overflow = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Start && !w_b_zero) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_dvd     <= '0;
            r_div     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_q       <= '0;
            r_r       <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_dvd <= w_a_mag;
                        r_div <= w_b_mag;
                        r_rem <= '0;
                        r_cnt <= CW'(N);
                        if (w_b_zero) begin
                            r_done    <= 1'b1;
                            r_divzero <= 1'b1;
                            r_q       <= '1;
                            r_r       <= A;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt[N-1:0];
                    r_dvd <= w_dvd_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_q       <= w_q_fin;
                        r_r       <= w_r_fin;
                        r_done    <= 1'b1;
                        r_divzero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q       = r_q;
    assign R       = r_r;
    assign Busy    = (r_state == S_RUN);
    assign Done    = r_done;
    assign DivZero = r_divzero;

endmodule
`default_nettype wire
